// File: rtl/plu_mac_seq.sv
// Sequential perceptron unit: out = sat((sum w_i*a_i) >>> FRAC) with optional ReLU,
// LANES multiply-accumulates per cycle over N_CH channels.
module plu_mac_seq #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int N_CH  = 8,
  parameter int LANES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                relu_en,
  input  logic [N_CH*W-1:0]   w_flat,
  input  logic [N_CH*W-1:0]   a_flat,
  output logic [W-1:0]        out,
  output logic                done,
  output logic                busy,
  output logic                ovf
);

  localparam int G  = N_CH / LANES;
  localparam int AW = 2*W + $clog2(N_CH) + 1;
  localparam int IW = (G > 1) ? $clog2(G) : 1;

  localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  generate
    if ((N_CH % LANES) != 0) begin : g_lanes_check
      $error("plu_mac_seq: N_CH must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FINAL} state_t;

  state_t               state;
  logic [N_CH*W-1:0]    w_sh;
  logic [N_CH*W-1:0]    a_sh;
  logic                 relu_lat;
  logic signed [AW-1:0] acc;
  logic [IW-1:0]        idx;

  logic signed [AW-1:0] psum [LANES+1];
  logic signed [AW-1:0] grp_sum;
  logic signed [AW-1:0] r;
  logic [W-1:0]         sat_val;
  logic [W-1:0]         res_val;
  logic                 sat_hit;

  // Latched operands shift down by one group per MAC cycle, so the lanes
  // always multiply the lowest LANES channels and need no channel mux.
  assign psum[0] = '0;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0]   wv;
    logic [W-1:0]   av;
    logic [2*W-1:0] p;
    assign wv = w_sh[l*W +: W];
    assign av = a_sh[l*W +: W];
    assign p  = {{W{wv[W-1]}}, wv} * {{W{av[W-1]}}, av};
    assign psum[l+1] = psum[l] + {{(AW-2*W){p[2*W-1]}}, p};
  end
  assign grp_sum = psum[LANES];

  always_comb begin
    r       = acc >>> FRAC;
    sat_hit = 1'b0;
    sat_val = r[W-1:0];
    if (r > MAXV) begin
      sat_val = {1'b0, {(W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (r < MINV) begin
      sat_val = {1'b1, {(W-1){1'b0}}};
      sat_hit = 1'b1;
    end
    res_val = (relu_lat && sat_val[W-1]) ? '0 : sat_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      w_sh     <= '0;
      a_sh     <= '0;
      relu_lat <= 1'b0;
      acc      <= '0;
      idx      <= '0;
      out      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            w_sh     <= w_flat;
            a_sh     <= a_flat;
            relu_lat <= relu_en;
            acc      <= '0;
            ovf      <= 1'b0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          acc  <= acc + grp_sum;
          w_sh <= w_sh >> (LANES*W);
          a_sh <= a_sh >> (LANES*W);
          idx  <= idx + 1'b1;
          if (idx == IW'(G-1)) state <= S_FINAL;
        end
        S_FINAL: begin
          out   <= res_val;
          ovf   <= sat_hit;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plu_mac_seq.sv
// Self-checking bench for plu_mac_seq: directed cases, randomized ops against an
// arithmetic reference model, handshake/reset behaviour and parameter variants.
module tb_plu_mac_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default configuration
  logic         start, relu_en;
  logic [255:0] w_flat, a_flat;
  logic [31:0]  out;
  logic         done, busy, ovf;

  plu_mac_seq #(.W(32), .FRAC(16), .N_CH(8), .LANES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .w_flat(w_flat), .a_flat(a_flat),
    .out(out), .done(done), .busy(busy), .ovf(ovf)
  );

  // Parameter variants, started together
  logic         g_start, g_relu;
  logic [255:0] g_w, g_a;
  logic [63:0]  h_w, h_a;
  logic [31:0]  out8, out1;
  logic [15:0]  out16;
  logic         done8, busy8, ovf8, done1, busy1, ovf1, done16, busy16, ovf16;

  plu_mac_seq #(.W(32), .FRAC(16), .N_CH(8), .LANES(8)) dut_l8 (
    .clk(clk), .rst(rst), .start(g_start), .relu_en(g_relu),
    .w_flat(g_w), .a_flat(g_a),
    .out(out8), .done(done8), .busy(busy8), .ovf(ovf8)
  );

  plu_mac_seq #(.W(32), .FRAC(16), .N_CH(8), .LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .start(g_start), .relu_en(g_relu),
    .w_flat(g_w), .a_flat(g_a),
    .out(out1), .done(done1), .busy(busy1), .ovf(ovf1)
  );

  plu_mac_seq #(.W(16), .FRAC(8), .N_CH(4), .LANES(2)) dut_w16 (
    .clk(clk), .rst(rst), .start(g_start), .relu_en(g_relu),
    .w_flat(h_w), .a_flat(h_a),
    .out(out16), .done(done16), .busy(busy16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, out} from wide signed arithmetic, W=32, FRAC=16, N_CH=8
  function automatic logic [32:0] model(input logic [255:0] wf, input logic [255:0] af,
                                        input logic relu);
    logic signed [95:0] s;
    logic signed [95:0] r;
    logic [31:0] o;
    logic v;
    s = '0;
    for (int i = 0; i < 8; i++)
      s = s + 96'($signed(wf[i*32 +: 32])) * 96'($signed(af[i*32 +: 32]));
    r = s >>> 16;
    v = 1'b0;
    if (r > 96'sd2147483647) begin
      o = 32'h7FFF_FFFF; v = 1'b1;
    end else if (r < -96'sd2147483648) begin
      o = 32'h8000_0000; v = 1'b1;
    end else begin
      o = r[31:0];
    end
    if (relu && o[31]) o = '0;
    return {v, o};
  endfunction

  function automatic logic [255:0] fill(input logic [31:0] v);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = v;
    return f;
  endfunction

  function automatic logic [255:0] rnd_vec(input logic full);
    logic [255:0] f;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      if (!full) v = {{12{v[19]}}, v[19:0]};
      f[i*32 +: 32] = v;
    end
    return f;
  endfunction

  // Full operation on the default instance; inputs are scrambled after the start edge.
  task automatic run_op(input string tag, input logic [255:0] w, input logic [255:0] a,
                        input logic relu);
    logic [32:0] exp;
    int lat, bcnt;
    exp = model(w, a, relu);
    w_flat = w; a_flat = a; relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; w_flat = ~w; a_flat = ~a; relu_en = ~relu;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd5);
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'd5);
    chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, " out"}, 64'(out), 64'(exp[31:0]));
    chk({tag, " ovf"}, 64'(ovf), 64'(exp[32]));
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " out_hold"}, 64'(out), 64'(exp[31:0]));
  endtask

  logic [255:0] basic_w, basic_a;
  int lat, gap, dcnt, lat8, lat1, lat16;

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; w_flat = '0; a_flat = '0;
    g_start = 1'b0; g_relu = 1'b0; g_w = '0; g_a = '0; h_w = '0; h_a = '0;
    basic_w = fill(32'h0001_0000);
    for (int i = 0; i < 8; i++) basic_a[i*32 +: 32] = 32'((i + 1) << 16);

    @(posedge clk); #1;
    chk("reset out", 64'(out), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("basic", basic_w, basic_a, 1'b0);
    chk("basic const", 64'(out), 64'h0024_0000);

    run_op("neg", fill(32'h0001_0000), fill(32'hFFFF_0000), 1'b0);
    chk("neg const", 64'(out), 64'hFFF8_0000);
    run_op("relu", fill(32'h0001_0000), fill(32'hFFFF_0000), 1'b1);
    chk("relu const", 64'(out), 64'h0);

    run_op("sat_pos", fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF), 1'b0);
    chk("sat_pos const", 64'({ovf, out}), 64'h1_7FFF_FFFF);
    run_op("sat_neg", fill(32'h7FFF_FFFF), fill(32'h8000_0000), 1'b0);
    chk("sat_neg const", 64'({ovf, out}), 64'h1_8000_0000);
    run_op("sat_relu", fill(32'h7FFF_FFFF), fill(32'h8000_0000), 1'b1);
    chk("sat_relu const", 64'({ovf, out}), 64'h1_0000_0000);
    run_op("after_sat", basic_w, basic_a, 1'b0);
    chk("after_sat ovf", 64'(ovf), 64'd0);

    // start while busy, with different inputs, is ignored
    w_flat = basic_w; a_flat = basic_a; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    w_flat = fill(32'h0002_0000); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("ignore latency", 64'(lat), 64'd5);
    chk("ignore out", 64'(out), 64'h0024_0000);
    @(posedge clk); #1;
    chk("ignore no_restart", 64'(busy), 64'd0);

    // start held through the done cycle: back-to-back op
    w_flat = basic_w; a_flat = basic_a; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b first latency", 64'(lat), 64'd5);
    chk("b2b first out", 64'(out), 64'h0024_0000);
    w_flat = fill(32'h0002_0000);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b accept busy", 64'(busy), 64'd1);
    gap = 1;
    while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
    chk("b2b gap", 64'(gap), 64'd6);
    chk("b2b second out", 64'(out), 64'h0048_0000);

    // reset during the second MAC cycle
    w_flat = basic_w; a_flat = basic_a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("midrst out", 64'(out), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("midrst quiet", 64'(dcnt), 64'd0);
    run_op("post_rst", basic_w, basic_a, 1'b0);
    chk("post_rst const", 64'(out), 64'h0024_0000);

    for (int n = 0; n < 24; n++) begin
      logic [255:0] rw, ra;
      rw = rnd_vec(n % 4 == 3);
      ra = rnd_vec(n % 4 == 3);
      run_op($sformatf("rand%0d", n), rw, ra, 1'($urandom_range(0, 1)));
    end

    // parameter variants
    g_w = basic_w; g_a = basic_a; g_relu = 1'b0;
    for (int i = 0; i < 4; i++) begin h_w[i*16 +: 16] = 16'h0100; h_a[i*16 +: 16] = 16'h0100; end
    g_start = 1'b1;
    @(posedge clk); #1;
    g_start = 1'b0;
    lat8 = 0; lat1 = 0; lat16 = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (done8  && lat8  == 0) lat8  = c;
      if (done1  && lat1  == 0) lat1  = c;
      if (done16 && lat16 == 0) lat16 = c;
    end
    chk("lanes8 latency", 64'(lat8), 64'd2);
    chk("lanes8 out", 64'(out8), 64'h0024_0000);
    chk("lanes1 latency", 64'(lat1), 64'd9);
    chk("lanes1 out", 64'(out1), 64'h0024_0000);
    chk("w16 latency", 64'(lat16), 64'd3);
    chk("w16 out", 64'(out16), 64'h0400);
    chk("variants ovf", 64'({ovf8, ovf1, ovf16}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plu_mac_seq.md
Name: plu_mac_seq

Overview:
- Parametrised sequential perceptron logic unit for the Maxnet datapath.
- Computes one neuron output: out = sat(sum over i of w_i*a_i), with an optional ReLU clamp.
- Has N_CH input channels, processed LANES per cycle through shared multipliers.
- Replaces the fixed 4-input, 32-bit unit. Adds width/channel/lane generics, signed fixed-point scaling, saturation with an overflow flag, and a busy flag.

Parameters:
- W, 32: signed two's-complement data width of weights, activations and output.
- FRAC, 16: fractional bits of the Q format; shared by w, a and out.
- N_CH, 8: number of input channels.
- LANES, 2: multipliers used per cycle. N_CH mod LANES must be 0, otherwise elaboration fails.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin an operation; sampled only in IDLE
- relu_en  input  1  clamp negative result to 0; latched with start
- w_flat  input  N_CH*W  weights; channel i in bits [i*W +: W]; latched with start
- a_flat  input  N_CH*W  activations; same packing as w_flat; latched with start
- out  output  W  result register
- done  output  1  one-cycle pulse when out is updated
- busy  output  1  high while an operation is in flight
- ovf  output  1  saturation occurred in the last completed operation

Behaviour:
- Reset (asynchronous, any state): state=IDLE, out=0, done=0, busy=0, ovf=0, accumulator=0, group index=0. An in-flight operation is aborted and no done is issued.
- Derived sizes:
  - G = N_CH/LANES.
  - Accumulator width AW = 2W + clog2(N_CH) + 1, signed. It never overflows internally.
- State IDLE:
  - start=1 at edge k: latch w_flat, a_flat and relu_en; clear accumulator; clear ovf; idx=0; go to MAC.
  - start=0: hold. out and ovf keep their values.
- State MAC, one edge per group:
  - acc += sign-extended sum of the 2W-bit signed products of channels idx*LANES .. idx*LANES+LANES-1; idx++.
  - After group G-1 (edge k+G), go to FINAL.
- State FINAL (edge k+G+1):
  - r = acc >>> FRAC, arithmetic shift (truncation toward -inf).
  - If r > 2^(W-1)-1: out=0x7F..F, ovf=1. If r < -2^(W-1): out=0x80..0, ovf=1. Otherwise out=r[W-1:0].
  - Then, if latched relu_en=1 and the saturated value is negative: out=0. ovf still reflects the saturation.
  - done=1 for exactly the cycle after this edge; go to IDLE.
- Latency: start sampled at edge k, out valid and done high after edge k+G+1, i.e. G+1 cycles.
- busy: high after edge k until edge k+G+1 (states MAC, FINAL); low in the done cycle.
- Back-to-back: start asserted during the done cycle is accepted (state is IDLE), giving a throughput of one result per G+2 cycles.
- start while busy is ignored, with no queueing. Input changes after the start edge have no effect.
- out is stable between done pulses. done is never asserted without a completed FINAL.

Test Plan (W=32, FRAC=16, N_CH=8, LANES=2 unless stated):
- Basic sum: all w=0x00010000 (1.0), a_i=(i+1)*0x00010000, relu_en=0 -> out=0x00240000 (36.0), done pulse 5 cycles after start edge, busy high 5 cycles, ovf=0.
- ReLU mode: w=1.0, all a=0xFFFF0000 (-1.0):
  - relu_en=0 -> out=0xFFF80000 (-8.0).
  - repeat with relu_en=1 -> out=0x00000000, ovf=0.
- Saturation: all w=a=0x7FFFFFFF -> out=0x7FFFFFFF, ovf=1. All w=0x7FFFFFFF, a=0x80000000 -> out=0x80000000, ovf=1. A following basic op clears ovf to 0.
- Handshake:
  - start pulsed again 2 cycles into an op with changed inputs -> ignored, original result delivered.
  - start held high through the done cycle -> second op starts immediately, second done 6 cycles after the first.
- Reset mid-op: assert rst at the 2nd MAC cycle -> out=0, busy=0, done never pulses. The next start with basic-sum stimulus gives 0x00240000.
- Generics: LANES=8 -> latency 2 cycles, same 36.0 result. LANES=1 -> latency 9 cycles. W=16, FRAC=8, N_CH=4, w=a=0x0100 -> out=0x0400.
